// File: rtl/bf16_fp8_drain.sv
// bf16_fp8_drain: BF16 -> FP8 E4M3 requantizer and byte packer.
// A convert stage rounds each BF16 value to E4M3 (round-to-nearest-even).
// A pack stage then collects four bytes per 32-bit word, first byte in [7:0].
// Both stages honour valid/ready backpressure and sustain one value per cycle.
module bf16_fp8_drain #(
  parameter bit SATURATE = 1'b1,  // 1: overflow clamps to +/-240, 0: overflow becomes +/-Inf
  parameter int CNT_W    = 16     // width of the saturation event counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_keep,
  output logic             out_last,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count,
  output logic             nan_seen
);

  // ---------------------------------------------------------------------------
  // BF16 field split
  // ---------------------------------------------------------------------------
  logic       w_sign;
  logic [7:0] w_exp;
  logic [6:0] w_mant;

  assign {w_sign, w_exp, w_mant} = in_data;

  // ---------------------------------------------------------------------------
  // Normal range (biased exp >= 121, i.e. E >= -6): keep mant[6:4] and round
  // on guard mant[3] and sticky mant[2:0].
  // ---------------------------------------------------------------------------
  logic       w_n_rup;
  logic [3:0] w_n_sum;    // {carry, 3-bit mantissa}
  logic [8:0] w_n_exp;    // BF16 biased exponent after a rounding carry
  logic       w_n_ovf;
  logic [3:0] w_n_field;  // E4M3 exponent field = E + 7 = biased_bf16 - 120

  assign w_n_rup   = w_mant[3] & ((|w_mant[2:0]) | w_mant[4]);
  assign w_n_sum   = {1'b0, w_mant[6:4]} + {3'b000, w_n_rup};
  assign w_n_exp   = {1'b0, w_exp} + {8'h00, w_n_sum[3]};
  // Rounded E above 7 (biased 134) cannot be represented as a finite E4M3.
  assign w_n_ovf   = w_n_exp > 9'd134;
  assign w_n_field = 4'(w_n_exp - 9'd120);

  // ---------------------------------------------------------------------------
  // Subnormal range (E < -6): the E4M3 result is an integer count of 2^-9.
  // {1,mant} sits at bits [23:16]; shifting right by (-6-E) lands the integer
  // part in [23:20], guard in [19] and sticky in [18:0]. The 16 zero pad bits
  // cover every shift up to 10 without losing sticky information.
  // ---------------------------------------------------------------------------
  logic [7:0]  w_sh;
  logic [23:0] w_sub_y;
  logic        w_sub_rup;
  logic [3:0]  w_sub_sum;  // 8 means rounding reached 2^-6, encoded as 0x08

  assign w_sh      = 8'd121 - w_exp;
  assign w_sub_y   = {1'b1, w_mant, 16'h0000} >> w_sh[3:0];
  assign w_sub_rup = w_sub_y[19] & ((|w_sub_y[18:0]) | w_sub_y[20]);
  assign w_sub_sum = w_sub_y[23:20] + {3'b000, w_sub_rup};

  // ---------------------------------------------------------------------------
  // Conversion result and event flags
  // ---------------------------------------------------------------------------
  logic [7:0] w_fp8;
  logic       w_ovf;
  logic       w_nan;

  // Select the E4M3 encoding by input class.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_fp8 = {w_sign, 7'h00};
    w_ovf = 1'b0;
    w_nan = 1'b0;
    if (&w_exp) begin
      if (w_mant != 7'h00) begin
        w_fp8 = 8'h7F;
        w_nan = 1'b1;
      end else begin
        w_fp8 = {w_sign, 7'h78};
      end
    end else if (w_exp == 8'h00) begin
      w_fp8 = {w_sign, 7'h00};
    end else if (w_exp < 8'd121) begin
      // Shifts beyond 10 are entirely below half of 2^-9 and flush to zero.
      if (w_sh <= 8'd10) begin
        w_fp8 = {w_sign, 3'b000, w_sub_sum};
      end
    end else if (w_n_ovf) begin
      w_ovf = 1'b1;
      w_fp8 = SATURATE ? {w_sign, 7'h77} : {w_sign, 7'h78};
    end else begin
      w_fp8 = {w_sign, w_n_field, w_n_sum[2:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic       r_c_valid;
  logic [7:0] r_c_byte;
  logic       r_c_last;
  logic       r_out_valid;
  logic [31:0] r_out_data;
  logic [3:0] r_out_keep;
  logic       r_out_last;
  logic [1:0] r_idx;
  logic [CNT_W-1:0] r_sat_count;
  logic       r_nan_seen;

  logic w_c_adv;
  logic w_in_fire;

  // C advances whenever the output register is empty or being drained.
  assign w_c_adv   = r_c_valid & (~r_out_valid | out_ready);
  assign in_ready  = ~r_c_valid | w_c_adv;
  assign w_in_fire = in_valid & in_ready;

  // Convert stage register: load on accept, empty when its byte moves on.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too; the whole block must read 0 after reset.
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_byte  <= 8'h00;
      r_c_last  <= 1'b0;
    end else if (w_in_fire) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_c_valid <= 1'b1;
      r_c_byte  <= w_fp8;
      r_c_last  <= in_last;
    end else if (w_c_adv) begin
      r_c_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pack stage
  // ---------------------------------------------------------------------------
  logic [31:0] w_base_data;
  logic [3:0]  w_base_keep;
  logic [31:0] w_pack_data;
  logic [3:0]  w_pack_keep;
  logic        w_close;

  // Merge the C byte into the current word; a word being handed off is
  // replaced by a fresh one so the new byte lands in lane 0 alone.
  always_comb begin
    w_base_data = r_out_valid ? 32'h0000_0000 : r_out_data;
    w_base_keep = r_out_valid ? 4'b0000 : r_out_keep;
    w_pack_data = w_base_data;
    case (r_idx)
      2'd0:    w_pack_data[7:0]   = r_c_byte;
      2'd1:    w_pack_data[15:8]  = r_c_byte;
      2'd2:    w_pack_data[23:16] = r_c_byte;
      default: w_pack_data[31:24] = r_c_byte;
    endcase
    w_pack_keep = w_base_keep | (4'b0001 << r_idx);
    w_close     = (r_idx == 2'd3) | r_c_last;
  end

  // Output word register: fill lanes, close on lane 3 or tile end, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0000_0000;
      r_out_keep  <= 4'b0000;
      r_out_last  <= 1'b0;
      r_idx       <= 2'd0;
    end else if (w_c_adv) begin
      r_out_data  <= w_pack_data;
      r_out_keep  <= w_pack_keep;
      r_out_valid <= w_close;
      r_out_last  <= w_close & r_c_last;
      r_idx       <= w_close ? 2'd0 : r_idx + 2'd1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0000_0000;
      r_out_keep  <= 4'b0000;
      r_out_last  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Status: saturation counter and sticky NaN flag, updated at C load
  // ---------------------------------------------------------------------------

  // Clear wins over a same-cycle event; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
      r_nan_seen  <= 1'b0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
      r_nan_seen  <= 1'b0;
    end else if (w_in_fire) begin
      if (w_ovf && (r_sat_count != {CNT_W{1'b1}})) begin
        r_sat_count <= r_sat_count + CNT_W'(1);
      end
      if (w_nan) begin
        r_nan_seen <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;
  assign sat_count = r_sat_count;
  assign nan_seen  = r_nan_seen;

endmodule

// File: tb/tb_bf16_fp8_drain.sv
// tb_bf16_fp8_drain: directed steps plus a randomized phase for bf16_fp8_drain.
// Expected bytes come from a real-arithmetic E4M3 rounding model; expected
// words come from a byte-queue packer; a monitor scores every handed-off word.
module tb_bf16_fp8_drain;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;
  logic        sat_clr;

  logic        in_ready,  in_ready0;
  logic        out_valid, out_valid0;
  logic [31:0] out_data,  out_data0;
  logic [3:0]  out_keep,  out_keep0;
  logic        out_last,  out_last0;
  logic [15:0] sat_count, sat_count0;
  logic        nan_seen,  nan_seen0;

  bf16_fp8_drain #(.SATURATE(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .sat_clr(sat_clr), .sat_count(sat_count), .nan_seen(nan_seen)
  );

  // Same stream through the Inf-on-overflow variant.
  bf16_fp8_drain #(.SATURATE(1'b0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_keep(out_keep0), .out_last(out_last0),
    .sat_clr(sat_clr), .sat_count(sat_count0), .nan_seen(nan_seen0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t       exp_q[$];
  word_t       mon_w;
  logic [31:0] mp_data;
  logic [3:0]  mp_keep;
  int          mp_idx;
  int          exp_sat;
  logic        exp_nan;
  int          n_assert;
  int          n_fail;
  bit          rnd_bp;
  logic [31:0] rnd;
  logic [15:0] rd;
  int          wait_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real rne(input real x);
    real f, d;
    f = $floor(x);
    d = x - f;
    if (d > 0.5) return f + 1.0;
    if (d < 0.5) return f;
    return ($floor(f / 2.0) * 2.0 == f) ? f : f + 1.0;
  endfunction

  // Real-valued reference: decode BF16, round to the nearest E4M3 value.
  function automatic logic [7:0] ref_fp8(input logic [15:0] b, input bit sat,
                                         output bit ovf, output bit nan);
    int   e, m, ee;
    real  mag, q, sc;
    logic s;
    ovf = 1'b0;
    nan = 1'b0;
    s = b[15];
    e = int'(b[14:7]);
    m = int'(b[6:0]);
    if (e == 255) begin
      if (m != 0) begin
        nan = 1'b1;
        return 8'h7F;
      end
      return {s, 7'h78};
    end
    if (e == 0) return {s, 7'h00};
    ee  = e - 127;
    mag = (1.0 + m / 128.0) * pow2(ee);
    if (mag < pow2(-6)) begin
      q = rne(mag / pow2(-9));
      return {s, 7'(int'(q))};
    end
    sc = rne(mag / pow2(ee) * 8.0);
    if (sc >= 16.0) begin
      ee = ee + 1;
      sc = 8.0;
    end
    if (ee > 7) begin
      ovf = 1'b1;
      return sat ? {s, 7'h77} : {s, 7'h78};
    end
    return {s, 4'(ee + 7), 3'(int'(sc) - 8)};
  endfunction

  task automatic model_push(input logic [7:0] b, input logic l);
    mp_data[8*mp_idx +: 8] = b;
    mp_keep[mp_idx] = 1'b1;
    mp_idx++;
    if (mp_idx == 4 || l) begin
      exp_q.push_back('{d: mp_data, k: mp_keep, l: l});
      mp_data = '0;
      mp_keep = '0;
      mp_idx  = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mp_data = '0;
    mp_keep = '0;
    mp_idx  = 0;
    exp_sat = 0;
    exp_nan = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one value, wait (bounded) for acceptance, update the model on the accept edge.
  task automatic send(input logic [15:0] d, input logic l);
    int   n = 0;
    bit   ovf, nan;
    logic [7:0] b;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready || n > 200) break;
      n++;
      if (rnd_bp) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    check("accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    b = ref_fp8(d, 1'b1, ovf, nan);
    if (sat_clr) begin
      exp_sat = 0;
      exp_nan = 1'b0;
    end else begin
      if (ovf) exp_sat++;
      if (nan) exp_nan = 1'b1;
    end
    model_push(b, l);
    #1;
    in_valid = 1'b0;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_word(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Score every word handed downstream against the packer model.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("word_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_w = exp_q.pop_front();
        check("mon_data", out_data, mon_w.d);
        check("mon_keep", 32'(out_keep), 32'(mon_w.k));
        check("mon_last", 32'(out_last), 32'(mon_w.l));
      end
    end
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rnd_bp   = 1'b0;
    model_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_keep",      32'(out_keep),  32'd0);
    check("rst_sat",       32'(sat_count), 32'd0);
    check("rst_nan",       32'(nan_seen),  32'd0);
    rst = 1'b0;
    tick();

    // Basic values: RNE ties and the smallest negative subnormal.
    send(16'h3F80, 1'b0);
    send(16'h3F88, 1'b0);
    send(16'h3F98, 1'b0);
    send(16'hBB00, 1'b1);
    wait_word("basic");
    check("basic_data", out_data, 32'h813A_3838);
    check("basic_keep", 32'(out_keep), 32'hF);
    check("basic_last", 32'(out_last), 32'd1);
    check("basic_sat",  32'(sat_count), 32'd0);
    tick();

    // Overflow: clamp vs Inf, both counted.
    send(16'h4396, 1'b0);
    send(16'h4378, 1'b1);
    wait_word("ovf");
    check("ovf_data",  out_data, 32'h0000_7777);
    check("ovf_keep",  32'(out_keep), 32'h3);
    check("ovf_last",  32'(out_last), 32'd1);
    check("ovf_sat",   32'(sat_count), 32'd2);
    check("ovf_data0", out_data0, 32'h0000_7878);
    check("ovf_sat0",  32'(sat_count0), 32'd2);
    tick();

    // Clear, then clear colliding with an overflow event.
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    exp_sat = 0;
    exp_nan = 1'b0;
    check("clr_sat",  32'(sat_count),  32'd0);
    check("clr_sat0", 32'(sat_count0), 32'd0);
    sat_clr = 1'b1;
    send(16'h4396, 1'b1);
    sat_clr = 1'b0;
    check("clr_prio_sat", 32'(sat_count), 32'd0);
    wait_word("prio");
    check("prio_data", out_data, 32'h0000_0077);
    check("prio_keep", 32'(out_keep), 32'h1);
    tick();

    // Special values.
    send(16'h7F80, 1'b0);
    send(16'hFF80, 1'b0);
    send(16'h7FC1, 1'b0);
    send(16'h8000, 1'b1);
    wait_word("spec");
    check("spec_data", out_data, 32'h807F_F878);
    check("spec_keep", 32'(out_keep), 32'hF);
    check("spec_nan",  32'(nan_seen), 32'd1);
    check("spec_sat",  32'(sat_count), 32'd0);
    tick();

    // Packing: five values, handoff and fresh word on the same edge.
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h4040, 1'b0);
    send(16'h4080, 1'b0);
    send(16'h40A0, 1'b1);
    wait_word("pack1");
    check("pack1_data", out_data, 32'h4844_4038);
    check("pack1_keep", 32'(out_keep), 32'hF);
    check("pack1_last", 32'(out_last), 32'd0);
    @(posedge clk);
    wait_word("pack2");
    check("pack2_data", out_data, 32'h0000_004A);
    check("pack2_keep", 32'(out_keep), 32'h1);
    check("pack2_last", 32'(out_last), 32'd1);
    tick();

    // Backpressure: full word held, C full, input stalled.
    out_ready = 1'b0;
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b0);
    send(16'h4040, 1'b0);
    send(16'h4080, 1'b0);
    send(16'h40A0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h40C0;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_data",      out_data,       32'h4844_4038);
    end
    tick();
    out_ready = 1'b1;
    send(16'h40C0, 1'b1);
    wait_word("bp2");
    check("bp2_data", out_data, 32'h0000_4C4A);
    check("bp2_keep", 32'(out_keep), 32'h3);
    check("bp2_last", 32'(out_last), 32'd1);
    tick();

    // Reset mid-word drops the partial word and the counter at once.
    send(16'h4396, 1'b0);
    send(16'h3F80, 1'b0);
    check("pre_rst_sat", 32'(sat_count), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sat",       32'(sat_count), 32'd0);
    check("mid_rst_keep",      32'(out_keep),  32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    send(16'h4000, 1'b0);
    send(16'h4040, 1'b0);
    send(16'h4080, 1'b0);
    send(16'h40A0, 1'b0);
    wait_word("post_rst");
    check("post_rst_data", out_data, 32'h4A48_4440);
    check("post_rst_keep", 32'(out_keep), 32'hF);
    check("post_rst_last", 32'(out_last), 32'd0);
    tick();

    // Randomized values, tile ends and downstream stalls.
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rnd = $urandom;
      rd  = rnd[15:0];
      if (rnd[16]) rd[14:7] = 8'($urandom_range(112, 138));
      if (rnd[17]) rd[2:0]  = 3'b000;
      send(rd, (i == 299) || ($urandom_range(0, 7) == 0));
    end
    rnd_bp    = 1'b0;
    out_ready = 1'b1;
    wait_n    = 0;
    while (exp_q.size() != 0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    check("final_sat",   32'(sat_count), 32'(exp_sat));
    check("final_nan",   32'(nan_seen),  32'(exp_nan));
    check("final_idle",  32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
